// File: rtl/multi_cycle_ctrl.sv
// Control FSM for the multi-cycle MIPS datapath: sequences FETCH/DECODE/EXEC/WB,
// decodes the latched instruction into ALU and datapath controls, counts retired
// instructions.
module multi_cycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instruction,
  input  logic             Zero,
  output logic [1:0]       State,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             ExtOp,
  output logic             LuiOp,
  output logic [1:0]       PCSource,
  output logic [4:0]       ALUConf,
  output logic             Sign,
  output logic [CNT_W-1:0] InstrCount
);

  localparam int unsigned ALU_W = 5;

  localparam logic [ALU_W-1:0] ALU_ADD  = 5'h00;
  localparam logic [ALU_W-1:0] ALU_SUB  = 5'h01;
  localparam logic [ALU_W-1:0] ALU_AND  = 5'h02;
  localparam logic [ALU_W-1:0] ALU_OR   = 5'h03;
  localparam logic [ALU_W-1:0] ALU_XOR  = 5'h04;
  localparam logic [ALU_W-1:0] ALU_NOR  = 5'h05;
  localparam logic [ALU_W-1:0] ALU_SL   = 5'h06;
  localparam logic [ALU_W-1:0] ALU_SR   = 5'h07;
  localparam logic [ALU_W-1:0] ALU_SLT  = 5'h08;
  localparam logic [ALU_W-1:0] ALU_PASS2 = 5'h10;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    C_NOP, C_RALU, C_SHIFT, C_J, C_JAL, C_JR, C_JALR,
    C_BEQ, C_BNE, C_IALU, C_LW, C_SW
  } iclass_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  iclass_e            icls;
  logic [ALU_W-1:0]   dec_alu;
  logic               dec_sign, dec_ext, dec_lui;

  logic [5:0] opcode, funct;
  assign opcode = Instruction[31:26];
  assign funct  = Instruction[5:0];

  // Register fields are consumed by the datapath, not by the controller.
  logic unused_fields;
  assign unused_fields = ^Instruction[25:6];

  assign State      = state_q;
  assign InstrCount = cnt_q;

  // Instruction decode: class plus ALU op / sign / extender controls.
  always_comb begin
    icls     = C_NOP;
    dec_alu  = ALU_ADD;
    dec_sign = 1'b0;
    dec_ext  = 1'b0;
    dec_lui  = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin icls = C_RALU; dec_sign = 1'b1; end
          6'h21: icls = C_RALU;
          6'h22: begin icls = C_RALU; dec_alu = ALU_SUB; dec_sign = 1'b1; end
          6'h23: begin icls = C_RALU; dec_alu = ALU_SUB; end
          6'h24: begin icls = C_RALU; dec_alu = ALU_AND; end
          6'h25: begin icls = C_RALU; dec_alu = ALU_OR;  end
          6'h26: begin icls = C_RALU; dec_alu = ALU_XOR; end
          6'h27: begin icls = C_RALU; dec_alu = ALU_NOR; end
          6'h2a: begin icls = C_RALU; dec_alu = ALU_SLT; dec_sign = 1'b1; end
          6'h2b: begin icls = C_RALU; dec_alu = ALU_SLT; end
          6'h00: begin icls = C_SHIFT; dec_alu = ALU_SL; end
          6'h02: begin icls = C_SHIFT; dec_alu = ALU_SR; end
          6'h03: begin icls = C_SHIFT; dec_alu = ALU_SR; dec_sign = 1'b1; end
          6'h08: icls = C_JR;
          6'h09: icls = C_JALR;
          default: icls = C_NOP;
        endcase
      end
      6'h02: icls = C_J;
      6'h03: icls = C_JAL;
      6'h04: begin icls = C_BEQ; dec_alu = ALU_SUB; dec_ext = 1'b1; end
      6'h05: begin icls = C_BNE; dec_alu = ALU_SUB; dec_ext = 1'b1; end
      6'h08: begin icls = C_IALU; dec_sign = 1'b1; dec_ext = 1'b1; end
      6'h09: begin icls = C_IALU; dec_ext = 1'b1; end
      6'h0a: begin icls = C_IALU; dec_alu = ALU_SLT; dec_sign = 1'b1; dec_ext = 1'b1; end
      6'h0b: begin icls = C_IALU; dec_alu = ALU_SLT; dec_ext = 1'b1; end
      6'h0c: begin icls = C_IALU; dec_alu = ALU_AND; end
      6'h0d: begin icls = C_IALU; dec_alu = ALU_OR;  end
      6'h0f: begin icls = C_IALU; dec_alu = ALU_PASS2; dec_lui = 1'b1; end
      6'h23: begin icls = C_LW; dec_ext = 1'b1; end
      6'h2b: begin icls = C_SW; dec_ext = 1'b1; end
      default: icls = C_NOP;
    endcase
  end

  // Next-state, datapath controls and retire counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 2'd0;
    MemtoReg = 2'd0;
    ALUSrcA  = 2'd0;
    ALUSrcB  = 2'd0;
    ExtOp    = 1'b0;
    LuiOp    = 1'b0;
    PCSource = 2'd0;
    ALUConf  = ALU_ADD;
    Sign     = 1'b0;

    // EXEC and WB share the operand and ALU selection of the instruction.
    if (state_q == S_EXEC || state_q == S_WB) begin
      ALUConf = dec_alu;
      Sign    = dec_sign;
      ExtOp   = dec_ext;
      LuiOp   = dec_lui;
      case (icls)
        C_SHIFT:            begin ALUSrcA = 2'd2; ALUSrcB = 2'd0; end
        C_IALU, C_LW, C_SW: begin ALUSrcA = 2'd1; ALUSrcB = 2'd2; end
        default:            begin ALUSrcA = 2'd1; ALUSrcB = 2'd0; end
      endcase
    end

    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'd1;
        PCWrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'd3;
        ExtOp   = 1'b1;
        state_d = S_FETCH;
        case (icls)
          C_J:    begin PCWrite = 1'b1; PCSource = 2'd2; end
          C_JAL:  begin
            PCWrite = 1'b1; PCSource = 2'd2;
            RegWrite = 1'b1; RegDst = 2'd2; MemtoReg = 2'd2;
          end
          C_JR:   begin PCWrite = 1'b1; PCSource = 2'd3; end
          C_JALR: begin
            PCWrite = 1'b1; PCSource = 2'd3;
            RegWrite = 1'b1; RegDst = 2'd1; MemtoReg = 2'd2;
          end
          C_NOP:  state_d = S_FETCH;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        state_d = S_WB;
        if (icls == C_BEQ || icls == C_BNE) begin
          PCSource = 2'd1;
          PCWrite  = (icls == C_BEQ) ? Zero : ~Zero;
          state_d  = S_FETCH;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        case (icls)
          C_RALU, C_SHIFT: begin RegWrite = 1'b1; RegDst = 2'd1; end
          C_IALU:          RegWrite = 1'b1;
          C_LW: begin
            MemRead = 1'b1; IorD = 1'b1; RegWrite = 1'b1; MemtoReg = 2'd1;
          end
          C_SW: begin MemWrite = 1'b1; IorD = 1'b1; end
          default: RegWrite = 1'b0;
        endcase
      end
    endcase

    if (state_d == S_FETCH)
      cnt_d = cnt_q + CNT_W'(1);

    // Reset suppresses every architectural write, whatever the state.
    if (!reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
  end

  // State and retire-count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed vector table, reset corner cases and a
// randomized run against an instruction-level reference model.
module tb_multi_cycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instruction;
  logic        Zero;
  logic [1:0]  State, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic        ExtOp, LuiOp, Sign;
  logic [4:0]  ALUConf;
  logic [31:0] InstrCount;

  logic [1:0]  unused_st, unused_rd, unused_m2r, unused_sa, unused_sb, unused_pcs;
  logic        unused_pcw, unused_iord, unused_mr, unused_mw, unused_irw, unused_rw;
  logic        unused_ext, unused_lui, unused_sign;
  logic [4:0]  unused_alu;
  logic [1:0]  cnt_small;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Instruction(Instruction), .Zero(Zero),
    .State(State), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtOp(ExtOp), .LuiOp(LuiOp), .PCSource(PCSource), .ALUConf(ALUConf),
    .Sign(Sign), .InstrCount(InstrCount)
  );

  // Narrow counter instance exercises wrap-around.
  multi_cycle_ctrl #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .Instruction(Instruction), .Zero(Zero),
    .State(unused_st), .PCWrite(unused_pcw), .IorD(unused_iord), .MemRead(unused_mr),
    .MemWrite(unused_mw), .IRWrite(unused_irw), .RegWrite(unused_rw),
    .RegDst(unused_rd), .MemtoReg(unused_m2r), .ALUSrcA(unused_sa), .ALUSrcB(unused_sb),
    .ExtOp(unused_ext), .LuiOp(unused_lui), .PCSource(unused_pcs), .ALUConf(unused_alu),
    .Sign(unused_sign), .InstrCount(cnt_small)
  );

  typedef struct packed {
    logic [1:0] st;
    logic       pcw, iord, mr, mw, irw, rw;
    logic [1:0] rdst, m2r, sa, sb;
    logic       ext, lui;
    logic [1:0] pcs;
    logic [4:0] alu;
    logic       sign;
  } outs_t;

  typedef struct packed {
    logic [4:0] alu;
    logic       sign, ext, lui;
    logic [1:0] sa, sb;
  } attr_t;

  typedef enum {
    I_ADD, I_ADDU, I_SUB, I_SUBU, I_AND, I_OR, I_XOR, I_NOR, I_SLT, I_SLTU,
    I_SLL, I_SRL, I_SRA, I_JR, I_JALR, I_J, I_JAL, I_BEQ, I_BNE,
    I_ADDI, I_ADDIU, I_SLTI, I_SLTIU, I_ANDI, I_ORI, I_LUI, I_LW, I_SW, I_BAD
  } op_e;

  typedef struct {
    logic [31:0] ins;
    logic        z;
    int          chk;
    int          lat;
    outs_t       exp;
  } vec_t;

  int          n_checks = 0;
  int          n_err    = 0;
  int          m_step   = 0;
  int unsigned m_cnt    = 0;
  outs_t       act;
  vec_t        vecs[20];

  logic [5:0] rfun [15] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22,
                            6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
  logic [5:0] iop  [13] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a, 6'h0b,
                            6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b};

  function automatic op_e dec(input logic [31:0] i);
    op_e o = I_BAD;
    if (i[31:26] == 6'h00) begin
      case (i[5:0])
        6'h20: o = I_ADD;  6'h21: o = I_ADDU; 6'h22: o = I_SUB;  6'h23: o = I_SUBU;
        6'h24: o = I_AND;  6'h25: o = I_OR;   6'h26: o = I_XOR;  6'h27: o = I_NOR;
        6'h2a: o = I_SLT;  6'h2b: o = I_SLTU; 6'h00: o = I_SLL;  6'h02: o = I_SRL;
        6'h03: o = I_SRA;  6'h08: o = I_JR;   6'h09: o = I_JALR;
        default: o = I_BAD;
      endcase
    end else begin
      case (i[31:26])
        6'h02: o = I_J;     6'h03: o = I_JAL;   6'h04: o = I_BEQ;  6'h05: o = I_BNE;
        6'h08: o = I_ADDI;  6'h09: o = I_ADDIU; 6'h0a: o = I_SLTI; 6'h0b: o = I_SLTIU;
        6'h0c: o = I_ANDI;  6'h0d: o = I_ORI;   6'h0f: o = I_LUI;  6'h23: o = I_LW;
        6'h2b: o = I_SW;
        default: o = I_BAD;
      endcase
    end
    return o;
  endfunction

  function automatic int lat_of(input op_e op);
    if (op inside {I_J, I_JAL, I_JR, I_JALR, I_BAD}) return 2;
    if (op inside {I_BEQ, I_BNE}) return 3;
    return 4;
  endfunction

  // {alu, sign, ext, lui, srcA, srcB} used during EXEC and WB.
  function automatic attr_t attrs(input op_e op);
    case (op)
      I_ADD:   return {5'h00, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0};
      I_ADDU:  return {5'h00, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0};
      I_SUB:   return {5'h01, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0};
      I_SUBU:  return {5'h01, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0};
      I_AND:   return {5'h02, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0};
      I_OR:    return {5'h03, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0};
      I_XOR:   return {5'h04, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0};
      I_NOR:   return {5'h05, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0};
      I_SLT:   return {5'h08, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0};
      I_SLTU:  return {5'h08, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0};
      I_SLL:   return {5'h06, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0};
      I_SRL:   return {5'h07, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0};
      I_SRA:   return {5'h07, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0};
      I_BEQ, I_BNE: return {5'h01, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0};
      I_ADDI:  return {5'h00, 1'b1, 1'b1, 1'b0, 2'd1, 2'd2};
      I_ADDIU: return {5'h00, 1'b0, 1'b1, 1'b0, 2'd1, 2'd2};
      I_SLTI:  return {5'h08, 1'b1, 1'b1, 1'b0, 2'd1, 2'd2};
      I_SLTIU: return {5'h08, 1'b0, 1'b1, 1'b0, 2'd1, 2'd2};
      I_ANDI:  return {5'h02, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2};
      I_ORI:   return {5'h03, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2};
      I_LUI:   return {5'h10, 1'b0, 1'b0, 1'b1, 2'd1, 2'd2};
      I_LW, I_SW: return {5'h00, 1'b0, 1'b1, 1'b0, 2'd1, 2'd2};
      default: return {5'h00, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0};
    endcase
  endfunction

  // Expected outputs for step `step` (0..3) of instruction `op`.
  function automatic outs_t model_out(input int step, input op_e op, input logic z,
                                      input logic rst_n);
    outs_t o;
    attr_t a;
    o = '0;
    a = attrs(op);
    o.st = 2'(step);
    if (step == 0) begin
      o.mr = 1'b1; o.irw = 1'b1; o.sb = 2'd1; o.pcw = 1'b1;
    end else if (step == 1) begin
      o.sb = 2'd3; o.ext = 1'b1;
      if (op inside {I_J, I_JAL})   begin o.pcw = 1'b1; o.pcs = 2'd2; end
      if (op inside {I_JR, I_JALR}) begin o.pcw = 1'b1; o.pcs = 2'd3; end
      if (op == I_JAL)  begin o.rw = 1'b1; o.rdst = 2'd2; o.m2r = 2'd2; end
      if (op == I_JALR) begin o.rw = 1'b1; o.rdst = 2'd1; o.m2r = 2'd2; end
    end else begin
      o.alu = a.alu; o.sign = a.sign; o.ext = a.ext; o.lui = a.lui;
      o.sa = a.sa; o.sb = a.sb;
      if (step == 2 && op inside {I_BEQ, I_BNE}) begin
        o.pcs = 2'd1;
        o.pcw = (op == I_BEQ) ? z : !z;
      end
      if (step == 3) begin
        if (op == I_LW) begin
          o.iord = 1'b1; o.mr = 1'b1; o.rw = 1'b1; o.m2r = 2'd1;
        end else if (op == I_SW) begin
          o.iord = 1'b1; o.mw = 1'b1;
        end else if (op inside {I_ADD, I_ADDU, I_SUB, I_SUBU, I_AND, I_OR, I_XOR,
                                I_NOR, I_SLT, I_SLTU, I_SLL, I_SRL, I_SRA}) begin
          o.rw = 1'b1; o.rdst = 2'd1;
        end else if (op inside {I_ADDI, I_ADDIU, I_SLTI, I_SLTIU, I_ANDI, I_ORI,
                                I_LUI}) begin
          o.rw = 1'b1;
        end
      end
    end
    if (!rst_n) begin
      o.pcw = 1'b0; o.irw = 1'b0; o.rw = 1'b0; o.mr = 1'b0; o.mw = 1'b0;
    end
    return o;
  endfunction

  function automatic outs_t mk(input int st, pcw, iord, mr, mw, irw, rw, rdst, m2r,
                               sa, sb, ext, lui, pcs, alu, sign);
    return {2'(st), 1'(pcw), 1'(iord), 1'(mr), 1'(mw), 1'(irw), 1'(rw), 2'(rdst),
            2'(m2r), 2'(sa), 2'(sb), 1'(ext), 1'(lui), 2'(pcs), 5'(alu), 1'(sign)};
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    int unsigned k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4)      r = {6'h00, r[25:6], rfun[$urandom_range(0, 14)]};
    else if (k < 9) r = {iop[$urandom_range(0, 12)], r[25:0]};
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic cycle(input logic [31:0] ins, input logic z, input logic rst_n);
    op_e op;
    Instruction = ins;
    Zero        = z;
    reset       = rst_n;
    #2;
    op  = dec(ins);
    act = {State, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst,
           MemtoReg, ALUSrcA, ALUSrcB, ExtOp, LuiOp, PCSource, ALUConf, Sign};
    check("outputs", 64'(act), 64'(model_out(m_step, op, z, rst_n)));
    check("count", 64'(InstrCount), 64'(m_cnt));
    check("count_wrap", 64'(cnt_small), 64'(2'(m_cnt)));
    if (!rst_n) begin
      m_step = 0;
      m_cnt  = 0;
    end else if (m_step + 1 == lat_of(op)) begin
      m_step = 0;
      m_cnt++;
    end else begin
      m_step++;
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int unsigned c0;
    n  = 0;
    c0 = InstrCount;
    do begin
      cycle(v.ins, v.z, 1'b1);
      if (n == v.chk) check($sformatf("vec%0d", idx), 64'(act), 64'(v.exp));
      n++;
    end while (State != 2'd0 && n < 8);
    check($sformatf("vec%0d_latency", idx), 64'(n), 64'(v.lat));
    check($sformatf("vec%0d_retire", idx), 64'(InstrCount), 64'(c0 + 1));
  endtask

  initial begin
    //        ins           z     chk lat  st pcw iord mr mw irw rw rdst m2r sa sb ext lui pcs alu  sign
    vecs[0]  = '{32'h00221820, 1'b0, 0, 4, mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 'h00, 0)};
    vecs[1]  = '{32'h00221820, 1'b0, 2, 4, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 'h00, 1)};
    vecs[2]  = '{32'h00221820, 1'b0, 3, 4, mk(3, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 'h00, 1)};
    vecs[3]  = '{32'h10220003, 1'b1, 2, 3, mk(2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 'h01, 0)};
    vecs[4]  = '{32'h10220003, 1'b0, 2, 3, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 'h01, 0)};
    vecs[5]  = '{32'h14220003, 1'b0, 2, 3, mk(2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 'h01, 0)};
    vecs[6]  = '{32'h14220003, 1'b1, 2, 3, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 'h01, 0)};
    vecs[7]  = '{32'h0C000010, 1'b0, 1, 2, mk(1, 1, 0, 0, 0, 0, 1, 2, 2, 0, 3, 1, 0, 2, 'h00, 0)};
    vecs[8]  = '{32'h08000010, 1'b0, 1, 2, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 2, 'h00, 0)};
    vecs[9]  = '{32'h03E00008, 1'b0, 1, 2, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 3, 'h00, 0)};
    vecs[10] = '{32'h0040F809, 1'b0, 1, 2, mk(1, 1, 0, 0, 0, 0, 1, 1, 2, 0, 3, 1, 0, 3, 'h00, 0)};
    vecs[11] = '{32'h8C220004, 1'b0, 3, 4, mk(3, 0, 1, 1, 0, 0, 1, 0, 1, 1, 2, 1, 0, 0, 'h00, 0)};
    vecs[12] = '{32'hAC220004, 1'b0, 3, 4, mk(3, 0, 1, 0, 1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 'h00, 0)};
    vecs[13] = '{32'h3C021234, 1'b0, 3, 4, mk(3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 0, 1, 0, 'h10, 0)};
    vecs[14] = '{32'h00021883, 1'b0, 2, 4, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 'h07, 1)};
    vecs[15] = '{32'h38221234, 1'b0, 1, 2, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 'h00, 0)};
    vecs[16] = '{32'h28220005, 1'b0, 2, 4, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 'h08, 1)};
    vecs[17] = '{32'h30220FFF, 1'b0, 3, 4, mk(3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 0, 0, 0, 'h02, 0)};
    vecs[18] = '{32'h00221827, 1'b0, 3, 4, mk(3, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 'h05, 0)};
    vecs[19] = '{32'h0022182B, 1'b0, 2, 4, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 'h08, 0)};

    // Reset held low across the first edges.
    reset       = 1'b0;
    Instruction = 32'h00221820;
    Zero        = 1'b0;
    @(negedge clk);
    cycle(32'h00221820, 1'b0, 1'b0);
    cycle(32'h00221820, 1'b0, 1'b0);
    check("reset_state", 64'(State), 64'd0);
    check("reset_count", 64'(InstrCount), 64'd0);

    for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

    // Reset during EXEC of sra abandons the instruction.
    cycle(32'h00021883, 1'b0, 1'b1);
    cycle(32'h00021883, 1'b0, 1'b1);
    check("sra_in_exec", 64'(State), 64'd2);
    cycle(32'h00021883, 1'b0, 1'b0);
    check("midreset_state", 64'(State), 64'd0);
    check("midreset_count", 64'(InstrCount), 64'd0);
    cycle(32'h00021883, 1'b0, 1'b1);
    check("midreset_decode", 64'(State), 64'd1);
    cycle(32'h00021883, 1'b0, 1'b1);
    cycle(32'h00021883, 1'b0, 1'b1);
    cycle(32'h00021883, 1'b0, 1'b1);

    // Randomized run with occasional resets.
    begin
      logic [31:0] ins;
      ins = 32'h0;
      for (int c = 0; c < 1500; c++) begin
        if (m_step == 0) ins = rand_ins();
        cycle(ins, 1'($urandom_range(0, 1)), ($urandom_range(0, 39) != 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Four-state control FSM for the multi-cycle MIPS datapath. It sits directly upstream of the ALU.
- It decodes the latched instruction, sequences FETCH/DECODE/EXEC/WB, and drives ALUConf, Sign, operand selects and every datapath write enable.
- It consumes the ALU Zero flag to resolve branches.
- It keeps a retired-instruction counter for performance checks.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- Instruction  in  32  instruction register contents.
- Zero  in  1  ALU zero flag.
- State  out  2  current state: FETCH=0, DECODE=1, EXEC=2, WB=3.
- PCWrite  out  1  PC register load enable.
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead, MemWrite  out  1 each  data/instruction memory strobes.
- IRWrite  out  1  instruction register load enable.
- RegWrite  out  1  register file write enable.
- RegDst  out  2  write register select: 0=rt, 1=rd, 2=$31.
- MemtoReg  out  2  write data select: 0=ALUOut, 1=MDR/memory, 2=PC.
- ALUSrcA  out  2  ALU In1 select: 0=PC, 1=rs data, 2=zero-extended shamt.
- ALUSrcB  out  2  ALU In2 select: 0=rt data, 1=const 4, 2=ext imm, 3=ext imm<<2.
- ExtOp  out  1  1 = sign-extend imm16, 0 = zero-extend.
- LuiOp  out  1  1 = extender outputs {imm16,16'b0}.
- PCSource  out  2  next PC select: 0=ALU result, 1=ALUOut, 2={PC[31:28],target,2'b00}, 3=rs data.
- ALUConf  out  5  ALU operation code.
- Sign  out  1  signed compare / arithmetic shift select.
- InstrCount  out  CNT_W  instructions retired since reset.

Behaviour:
- ALUConf encodings: ADD=5'h00, SUB=5'h01, AND=5'h02, OR=5'h03, XOR=5'h04, NOR=5'h05, SL=5'h06, SR=5'h07, SLT=5'h08, PASS_IN1=5'h09, PASS_IN2=5'h10.
- Registered signals are State and InstrCount only. All other outputs decode combinationally from State, Instruction and Zero.
- Default for every output not named in a state: 0, with ALUConf=ADD.
- Reset: while reset is sampled low at a clock edge, State becomes FETCH and InstrCount becomes 0.
- While reset is low, PCWrite, IRWrite, RegWrite, MemRead and MemWrite are forced to 0 regardless of State.
- Reset asserted mid-instruction abandons that instruction with no further writes.
- FETCH:
  - MemRead=1, IorD=0, IRWrite=1.
  - ALUSrcA=0, ALUSrcB=1, ADD, PCSource=0, PCWrite=1.
  - Next state: DECODE.
- DECODE:
  - ALUSrcA=0, ALUSrcB=3, ExtOp=1, ADD, so the branch target is latched into ALUOut.
  - j: PCWrite=1, PCSource=2.
  - jal: as j, plus RegWrite=1, RegDst=2, MemtoReg=2.
  - jr: PCWrite=1, PCSource=3.
  - jalr: as jr, plus RegWrite=1, RegDst=1, MemtoReg=2.
  - Jumps and unsupported opcodes/functs go to FETCH and retire. Unsupported instructions retire as NOP with no writes.
  - All other instructions go to EXEC.
- EXEC:
  - R-type arithmetic/logic: ALUSrcA=1, ALUSrcB=0.
  - sll/srl/sra: ALUSrcA=2, ALUSrcB=0.
  - I-type and lw/sw: ALUSrcA=1, ALUSrcB=2.
  - beq/bne: ALUSrcA=1, ALUSrcB=0, SUB, PCSource=1. PCWrite=Zero for beq, PCWrite=~Zero for bne. Next state FETCH, retire.
  - Everything else goes to WB.
- ALU op mapping:
  - add/addu/addi/addiu/lw/sw: ADD.
  - sub/subu: SUB.
  - and/andi: AND. or/ori: OR. xor: XOR. nor: NOR.
  - sll: SL. srl/sra: SR. slt/sltu/slti/sltiu: SLT.
  - lui: PASS_IN2 with LuiOp=1.
- Sign=1 for add, sub, slt, slti, sra, addi. Sign=0 otherwise.
- ExtOp=1 for addi, addiu, slti, sltiu, lw, sw, beq, bne. ExtOp=0 for andi, ori, lui.
- WB (decode signals as in EXEC are held):
  - R-type: RegWrite=1, RegDst=1, MemtoReg=0.
  - I-type ALU: RegWrite=1, RegDst=0, MemtoReg=0.
  - lw: MemRead=1, IorD=1, RegWrite=1, RegDst=0, MemtoReg=1.
  - sw: MemWrite=1, IorD=1.
  - Next state: FETCH, retire.
- Retire means InstrCount increments by 1 on the edge that enters FETCH from a non-reset state. InstrCount wraps from all-ones to 0.
- Latency in cycles: jumps 2, branches 3, all other instructions 4.

Test Plan:
- Reset low 2 cycles with Instruction=add $3,$1,$2 -> State=0, InstrCount=0, all write enables 0. Release -> FETCH asserts IRWrite=1, PCWrite=1, ALUConf=5'h00.
- add $3,$1,$2 (0x00221820) -> states 0,1,2,3,0. EXEC: ALUConf=0x00, Sign=1, ALUSrcA=1, ALUSrcB=0. WB: RegWrite=1, RegDst=1. InstrCount=1.
- beq (0x10220003) with Zero=1 then Zero=0 -> EXEC PCWrite=1 then 0, ALUConf=0x01, PCSource=1. Each returns to FETCH after 3 cycles.
- jal (0x0C000010) -> DECODE PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemtoReg=2. Next State=0.
- lw (0x8C220004) / sw (0xAC220004) / lui (0x3C021234) -> WB MemRead+RegWrite+MemtoReg=1 / MemWrite=1, RegWrite=0 / ALUConf=0x10, LuiOp=1, RegWrite=1.
- sra (0x00021883) -> ALUSrcA=2, ALUConf=0x07, Sign=1. Assert reset low during EXEC -> next State=0, no RegWrite pulse, InstrCount=0.
